cache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache between pipeline and memory.

---
 rtl/cache_nway_wb.sv | 215 +++++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU
// replacement, a latched miss address and a whole-cache flush command.
module cache_nway_wb #(
    parameter int WAYS   = 2,
    parameter int SETS   = 4,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 30
) (
    input  logic                              clk,
    input  logic                              proc_reset_n,
    input  logic                              proc_read,
    input  logic                              proc_write,
    input  logic                              proc_flush,
    input  logic [ADDR_W-1:0]                 proc_addr,
    input  logic [31:0]                       proc_wdata,
    output logic [31:0]                       proc_rdata,
    output logic                              proc_stall,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_addr,
    output logic [32*WORDS-1:0]               mem_wdata,
    input  logic [32*WORDS-1:0]               mem_rdata,
    input  logic                              mem_ready
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BA_W  = ADDR_W - OFF_W;
    localparam int FL_W  = IDX_W + WAY_W;
    localparam int LINES = SETS * WAYS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_FLUSH} state_t;
    typedef logic [WORDS-1:0][31:0]     block_t;
    typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

    // Age of way w starts at w, so every set begins as a valid permutation.
    function automatic ages_t age_init();
        ages_t a;
        for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction
    localparam ages_t AGE_INIT = age_init();

    // Make way k most recent; every younger-than-k way ages by one.
    function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] k);
        ages_t r;
        r = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == k)         r[w] = '0;
            else if (ages[w] < ages[k]) r[w] = ages[w] + WAY_W'(1);
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    block_t             data_q  [SETS][WAYS], data_d  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS], tag_d   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS],       valid_d [SETS];
    logic [WAYS-1:0]    dirty_q [SETS],       dirty_d [SETS];
    ages_t              age_q   [SETS],       age_d   [SETS];
    logic [BA_W-1:0]    miss_addr_q, miss_addr_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [FL_W-1:0]    flush_q, flush_d;

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx, m_idx, fl_set;
    logic [OFF_W-1:0]   off;
    logic [TAG_W-1:0]   m_tag;
    logic [WAY_W-1:0]   hit_way, victim, fl_way;
    logic               hit, found_inv, any_dirty, fl_dirty;

    assign tag    = proc_addr[ADDR_W-1 -: TAG_W];
    assign idx    = proc_addr[OFF_W +: IDX_W];
    assign off    = proc_addr[OFF_W-1:0];
    assign m_idx  = miss_addr_q[IDX_W-1:0];
    assign m_tag  = miss_addr_q[BA_W-1:IDX_W];
    assign fl_way = flush_q[WAY_W-1:0];
    assign fl_set = flush_q[FL_W-1:WAY_W];
    assign fl_dirty = valid_q[fl_set][fl_way] & dirty_q[fl_set][fl_way];

    // Lookup: hit way, replacement victim and whether any line needs writing back.
    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        any_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_inv && !valid_q[idx][w]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++)
                if (age_q[idx][w] == WAY_W'(WAYS-1)) victim = WAY_W'(w);
        end
        for (int s = 0; s < SETS; s++) any_dirty = any_dirty | (|(valid_q[s] & dirty_q[s]));
    end

    // Outputs decoded from the registered state and the arrays.
    always_comb begin
        proc_rdata = data_q[idx][hit_way][off];
        mem_read   = (state_q == S_FILL);
        mem_write  = (state_q == S_WB) || (state_q == S_FLUSH && fl_dirty);
        mem_addr   = '0;
        mem_wdata  = '0;
        proc_stall = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (proc_flush)                    proc_stall = any_dirty;
                else if (proc_write || proc_read)  proc_stall = !hit;
                else                               proc_stall = 1'b0;
            end
            S_WB: begin
                mem_addr  = {tag_q[m_idx][victim_q], m_idx};
                mem_wdata = data_q[m_idx][victim_q];
            end
            S_FILL:  mem_addr = miss_addr_q;
            S_FLUSH: begin
                mem_addr  = {tag_q[fl_set][fl_way], fl_set};
                mem_wdata = data_q[fl_set][fl_way];
            end
            default: ;
        endcase
    end

    // Next-state: hits update data/LRU, misses latch and go to WB/FILL, flush walks all lines.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        age_d       = age_q;
        miss_addr_d = miss_addr_q;
        victim_d    = victim_q;
        flush_d     = flush_q;
        case (state_q)
            S_IDLE: begin
                if (proc_flush) begin
                    if (any_dirty) state_d = S_FLUSH;
                end else if (proc_write || proc_read) begin
                    if (hit) begin
                        age_d[idx] = lru_touch(age_q[idx], hit_way);
                        if (proc_write) begin
                            data_d[idx][hit_way][off] = proc_wdata;
                            dirty_d[idx][hit_way]     = 1'b1;
                        end
                    end else begin
                        miss_addr_d = {tag, idx};
                        victim_d    = victim;
                        state_d     = (valid_q[idx][victim] && dirty_q[idx][victim]) ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: if (mem_ready) state_d = S_FILL;
            S_FILL: begin
                if (mem_ready) begin
                    data_d[m_idx][victim_q]  = mem_rdata;
                    tag_d[m_idx][victim_q]   = m_tag;
                    valid_d[m_idx][victim_q] = 1'b1;
                    dirty_d[m_idx][victim_q] = 1'b0;
                    age_d[m_idx]             = lru_touch(age_q[m_idx], victim_q);
                    state_d                  = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!fl_dirty || mem_ready) begin
                    dirty_d[fl_set][fl_way] = 1'b0;
                    if (flush_q == FL_W'(LINES-1)) begin
                        flush_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        flush_d = flush_q + FL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and array registers.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    // NOTE: the arrays are cleared by reset on purpose; this keeps them as flops rather than RAM.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q     <= S_IDLE;
            data_q      <= '{default: '0};
            tag_q       <= '{default: '0};
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
            age_q       <= '{default: AGE_INIT};
            miss_addr_q <= '0;
            victim_q    <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            age_q       <= age_d;
            miss_addr_q <= miss_addr_d;
            victim_q    <= victim_d;
            flush_q     <= flush_d;
        end
    end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Self-checking bench for cache_nway_wb (4-way, 4 sets, 4 words): directed
// vectors with expected memory traffic and load data queued for monitors,
// then a random phase against a reference memory.
module tb_cache_nway_wb;
    localparam int WAYS   = 4;
    localparam int SETS   = 4;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 30;
    localparam int BA_W   = ADDR_W - 2;

    logic                  clk;
    logic                  proc_reset_n, proc_read, proc_write, proc_flush;
    logic [ADDR_W-1:0]     proc_addr;
    logic [31:0]           proc_wdata, proc_rdata;
    logic                  proc_stall, mem_read, mem_write, mem_ready;
    logic [BA_W-1:0]       mem_addr;
    logic [32*WORDS-1:0]   mem_wdata, mem_rdata;

    typedef struct packed {
        logic            wr;
        logic [BA_W-1:0] addr;
        logic            chk_w1;
        logic [31:0]     w1;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem[int];
    logic [31:0] back_mem[int];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 1;
    bit          rand_lat = 0;
    bit          chk_mem  = 1;
    logic            obs_wr;
    logic [BA_W-1:0] obs_addr;
    logic [31:0]     obs_w1;
    event            txn_ev;

    cache_nway_wb #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read), .proc_write(proc_write),
        .proc_flush(proc_flush), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int wa);
        return 32'hD000_0000 ^ (wa * 32'h0001_0203);
    endfunction
    function automatic logic [31:0] ref_rd(input int wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : mem_init(wa);
    endfunction
    function automatic logic [31:0] back_rd(input int wa);
        return back_mem.exists(wa) ? back_mem[wa] : mem_init(wa);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_mem(input logic wr, input int blk, input logic chk_w1, input logic [31:0] w1);
        mem_exp_t e;
        e.wr = wr; e.addr = BA_W'(blk); e.chk_w1 = chk_w1; e.w1 = w1;
        exp_mem.push_back(e);
    endtask

    // One load or store; exp_stall0 < 0 means the first-cycle stall is not checked.
    task automatic do_access(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input int exp_stall0, output int stalls);
        @(posedge clk); #1;
        proc_addr = a; proc_wdata = d; proc_read = !wr; proc_write = wr;
        if (wr) ref_mem[int'(a)] = d;
        else    exp_rd.push_back(ref_rd(int'(a)));
        @(negedge clk);
        if (exp_stall0 >= 0) check(wr ? "wr_first_stall" : "rd_first_stall", 64'(proc_stall), 64'(exp_stall0));
        stalls = 0;
        while (proc_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (proc_stall) check("access_timeout", 64'(proc_stall), 64'(0));
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic do_flush(input int exp_stall0);
        int n;
        @(posedge clk); #1;
        proc_flush = 1'b1;
        @(negedge clk);
        if (exp_stall0 >= 0) check("flush_first_stall", 64'(proc_stall), 64'(exp_stall0));
        n = 0;
        while (proc_stall && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (proc_stall) check("flush_timeout", 64'(proc_stall), 64'(0));
        @(posedge clk); #1;
        proc_flush = 1'b0;
    endtask

    // Memory responder: latency counted in cycles the request waits before mem_ready.
    initial begin
        int wait_cnt;
        bit pending;
        mem_ready = 1'b0; mem_rdata = '0; pending = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!proc_reset_n || !(mem_read || mem_write)) begin
                pending = 0;
            end else begin
                if (!pending) begin
                    pending  = 1;
                    wait_cnt = rand_lat ? int'($urandom_range(0, 7)) : lat;
                    obs_wr = mem_write; obs_addr = mem_addr; obs_w1 = mem_wdata[63:32];
                    if (chk_mem) -> txn_ev;
                end
                if (wait_cnt == 0) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (mem_write) back_mem[int'(mem_addr) * WORDS + i] = mem_wdata[32*i +: 32];
                        else           mem_rdata[32*i +: 32] = back_rd(int'(mem_addr) * WORDS + i);
                    end
                    mem_ready = 1'b1;
                    pending   = 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Memory-traffic monitor.
    initial begin
        mem_exp_t e;
        forever begin
            @(txn_ev);
            if (exp_mem.size() == 0) begin
                check("mem_txn_queue", 64'(exp_mem.size()), 64'(1));
            end else begin
                e = exp_mem.pop_front();
                check("mem_kind", 64'(obs_wr), 64'(e.wr));
                check("mem_addr", 64'(obs_addr), 64'(e.addr));
                if (e.chk_w1) check("mem_wdata_w1", 64'(obs_w1), 64'(e.w1));
            end
        end
    end

    // Load-data monitor.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (proc_reset_n && proc_read && !proc_write && !proc_flush && !proc_stall) begin
                if (exp_rd.size() == 0) begin
                    check("rd_queue", 64'(exp_rd.size()), 64'(1));
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_data", 64'(proc_rdata), 64'(e));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int n;
        proc_reset_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_flush = 1'b0;
        proc_addr = '0; proc_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(proc_stall), 64'(0));
        check("rst_mem_read", 64'(mem_read), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        @(posedge clk); #1;
        proc_reset_n = 1'b1;

        // Cold read miss: fetch block 0, stall 2+L with L=1.
        push_mem(0, 'h0, 0, '0);
        do_access(0, 30'h000, '0, 1, st);
        check("clean_miss_stall_cycles", 64'(st), 64'(3));
        do_access(1, 30'h001, 32'h0000_CAFE, 0, st);
        do_access(0, 30'h001, '0, 0, st);

        // Fill set 0 (ways 1..3), then a fifth tag evicts dirty way 0.
        push_mem(0, 'h4, 0, '0);  do_access(0, 30'h010, '0, 1, st);
        push_mem(0, 'h8, 0, '0);  do_access(0, 30'h020, '0, 1, st);
        push_mem(0, 'hC, 0, '0);  do_access(0, 30'h030, '0, 1, st);
        push_mem(1, 'h0, 1, 32'h0000_CAFE);
        push_mem(0, 'h10, 0, '0);
        do_access(0, 30'h040, '0, 1, st);

        // LRU in set 1: A,B,C,D, hit A, miss E evicts B.
        push_mem(0, 'h1, 0, '0);  do_access(0, 30'h004, '0, 1, st);
        push_mem(0, 'h5, 0, '0);  do_access(0, 30'h014, '0, 1, st);
        push_mem(0, 'h9, 0, '0);  do_access(0, 30'h024, '0, 1, st);
        push_mem(0, 'hD, 0, '0);  do_access(0, 30'h034, '0, 1, st);
        do_access(0, 30'h004, '0, 0, st);
        push_mem(0, 'h11, 0, '0); do_access(0, 30'h044, '0, 1, st);
        do_access(0, 30'h024, '0, 0, st);
        do_access(0, 30'h034, '0, 0, st);
        do_access(0, 30'h004, '0, 0, st);
        push_mem(0, 'h5, 0, '0);  do_access(0, 30'h014, '0, 1, st);

        // LRU in set 2: A,B,C,D, hit A, hit B, miss E evicts C.
        push_mem(0, 'h2, 0, '0);  do_access(0, 30'h008, '0, 1, st);
        push_mem(0, 'h6, 0, '0);  do_access(0, 30'h018, '0, 1, st);
        push_mem(0, 'hA, 0, '0);  do_access(0, 30'h028, '0, 1, st);
        push_mem(0, 'hE, 0, '0);  do_access(0, 30'h038, '0, 1, st);
        do_access(0, 30'h008, '0, 0, st);
        do_access(0, 30'h018, '0, 0, st);
        push_mem(0, 'h12, 0, '0); do_access(0, 30'h048, '0, 1, st);
        do_access(0, 30'h008, '0, 0, st);
        do_access(0, 30'h018, '0, 0, st);
        do_access(0, 30'h038, '0, 0, st);
        push_mem(0, 'hA, 0, '0);  do_access(0, 30'h028, '0, 1, st);

        // Dirty (set1,way0) and (set3,way1), then flush writes both in order.
        do_access(1, 30'h005, 32'h1111_0001, 0, st);
        push_mem(0, 'h3, 0, '0);  do_access(0, 30'h00C, '0, 1, st);
        push_mem(0, 'h7, 0, '0);  do_access(1, 30'h01D, 32'h2222_0002, 1, st);
        push_mem(1, 'h1, 1, 32'h1111_0001);
        push_mem(1, 'h7, 1, 32'h2222_0002);
        do_flush(1);
        do_flush(0);
        do_access(0, 30'h005, '0, 0, st);
        do_access(0, 30'h01D, '0, 0, st);

        // Reset while mem_read is high aborts the fill at once.
        lat = 5;
        push_mem(0, 'h3F, 0, '0);
        @(posedge clk); #1;
        proc_addr = 30'h0FC; proc_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_read && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("pre_rst_mem_read", 64'(mem_read), 64'(1));
        #1;
        proc_reset_n = 1'b0;
        #1;
        check("mid_rst_mem_read", 64'(mem_read), 64'(0));
        check("mid_rst_mem_write", 64'(mem_write), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        proc_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        proc_reset_n = 1'b1;
        lat = 1;
        push_mem(0, 'h0, 0, '0);
        do_access(0, 30'h000, '0, 1, st);
        do_access(0, 30'h001, '0, 0, st);
        check("directed_mem_queue_empty", 64'(exp_mem.size()), 64'(0));

        // Random loads/stores over three times the capacity, random latency.
        chk_mem  = 0;
        rand_lat = 1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) do_flush(-1);
            else do_access(r < 50, ADDR_W'($urandom_range(0, 191)), $urandom, -1, st);
        end
        for (int a = 0; a < 192; a++) do_access(0, ADDR_W'(a), '0, -1, st);
        repeat (2) @(negedge clk);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
